// File: rtl/jesd_rx_multilane_path.sv
// JESD204B multi-lane receive front end: per-lane CGS/IFS tracking, octet
// alignment and deskew FIFOs that release all lanes together onto data_o.
module jesd_rx_multilane_path #(
    parameter int LANES           = 2,
    parameter int PARALLEL_OCTETS = 4,
    parameter int DATA_WIDTH      = PARALLEL_OCTETS * 8,
    parameter int BUFFER_DEPTH    = 16,
    parameter int CGS_THRESHOLD   = 4,
    parameter int ERR_THRESHOLD   = 3,
    localparam int AW             = (PARALLEL_OCTETS > 1) ? $clog2(PARALLEL_OCTETS) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [LANES*DATA_WIDTH-1:0]        gtx_data_i,
    input  logic [LANES*PARALLEL_OCTETS-1:0]   gtx_charisk_i,
    input  logic [LANES*PARALLEL_OCTETS-1:0]   gtx_notintable_i,
    input  logic [LANES*PARALLEL_OCTETS-1:0]   gtx_disperr_i,
    input  logic                               sync_request_i,
    input  logic                               release_i,
    output logic [LANES*DATA_WIDTH-1:0]        data_o,
    output logic                               data_valid_o,
    output logic                               sync_no,
    output logic [LANES-1:0]                   lane_cgs_o,
    output logic [LANES-1:0]                   lane_ifs_o,
    output logic [LANES*AW-1:0]                octet_align_o,
    output logic                               overflow_o,
    output logic                               underflow_o
);
    localparam int CW = $clog2(CGS_THRESHOLD + PARALLEL_OCTETS + 1);
    localparam int EW = $clog2(ERR_THRESHOLD + 1);
    localparam int PW = $clog2(BUFFER_DEPTH);

    typedef enum logic [2:0] {CS_INIT = 3'd0, CS_DATA = 3'd1} cs_state_e;

    logic [LANES-1:0] leave_s, empty_s, ifs_s, cgs_s, ovf_s, udf_s;
    logic             restart_s, start_s, pop_s;
    logic             data_valid_q, sync_no_q, overflow_q, underflow_q;

    // Any lane dropping out of CS_DATA restarts the whole link.
    assign restart_s = sync_request_i | (|leave_s);
    assign start_s   = release_i & (&ifs_s) & ~(|empty_s) & ~restart_s;
    assign pop_s     = (data_valid_q | start_s) & ~restart_s;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        logic [DATA_WIDTH-1:0]      cur_s, prev_q, aligned_q, data_q;
        logic [2*DATA_WIDTH-1:0]    shifted_s;
        logic [PARALLEL_OCTETS-1:0] err_oct_s, cgs_oct_s;
        logic [AW-1:0]              first_s, align_q, align_d;
        cs_state_e                  st_q, st_d;
        logic [CW-1:0]              cnt_q, cnt_d;
        logic [EW-1:0]              ecnt_q, ecnt_d;
        logic                       ifs_q, ifs_d, aligned_vld_q;
        logic [DATA_WIDTH-1:0]      mem_q [BUFFER_DEPTH];
        logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
        logic [PW:0]                count_q;
        logic                       full_s, wr_s, wr_ok_s, rd_ok_s;

        assign cur_s = gtx_data_i[n*DATA_WIDTH +: DATA_WIDTH];

        // Octet classification and lowest non-/K/ octet index.
        always_comb begin
            err_oct_s = '0;
            cgs_oct_s = '0;
            first_s   = '0;
            for (int k = PARALLEL_OCTETS - 1; k >= 0; k--) begin
                err_oct_s[k] = gtx_notintable_i[n*PARALLEL_OCTETS + k] | gtx_disperr_i[n*PARALLEL_OCTETS + k];
                cgs_oct_s[k] = gtx_charisk_i[n*PARALLEL_OCTETS + k] & ~err_oct_s[k]
                             & (cur_s[k*8 +: 5] == 5'd28) & (cur_s[k*8+5 +: 3] == 3'd5);
                first_s      = cgs_oct_s[k] ? first_s : AW'(k);
            end
        end

        // CGS state machine: /K/ counting in CS_INIT, error counting in CS_DATA.
        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            ecnt_d = ecnt_q;
            if (sync_request_i) begin
                st_d   = CS_INIT;
                cnt_d  = '0;
                ecnt_d = '0;
            end else begin
                case (st_q)
                    CS_INIT: begin
                        ecnt_d = '0;
                        if (&cgs_oct_s) begin
                            cnt_d = cnt_q + CW'(PARALLEL_OCTETS);
                        end else if (|err_oct_s) begin
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q;
                        end
                        if (cnt_d >= CW'(CGS_THRESHOLD)) begin
                            st_d  = CS_DATA;
                            cnt_d = '0;
                        end else begin
                            st_d = CS_INIT;
                        end
                    end
                    CS_DATA: begin
                        cnt_d  = '0;
                        ecnt_d = (|err_oct_s) ? ecnt_q + EW'(1) : '0;
                        if (ecnt_d >= EW'(ERR_THRESHOLD)) begin
                            st_d   = CS_INIT;
                            ecnt_d = '0;
                        end else begin
                            st_d = CS_DATA;
                        end
                    end
                    default: begin
                        st_d   = CS_INIT;
                        cnt_d  = '0;
                        ecnt_d = '0;
                    end
                endcase
            end
        end

        // IFS latch: first clean, non-/K/ word seen in CS_DATA fixes the alignment.
        always_comb begin
            ifs_d   = ifs_q;
            align_d = align_q;
            if (restart_s) begin
                ifs_d   = 1'b0;
                align_d = '0;
            end else if ((st_q == CS_DATA) && !ifs_q && !(|err_oct_s) && !(&cgs_oct_s)) begin
                ifs_d   = 1'b1;
                align_d = first_s;
            end else begin
                ifs_d   = ifs_q;
                align_d = align_q;
            end
        end

        assign leave_s[n] = (st_q == CS_DATA) && (st_d != CS_DATA);
        assign shifted_s  = {cur_s, prev_q} >> (32'(align_q) * 32'd8);
        assign full_s     = (count_q == (PW+1)'(BUFFER_DEPTH));
        assign empty_s[n] = (count_q == '0);
        assign wr_s       = aligned_vld_q & ifs_q & ~restart_s;
        assign wr_ok_s    = wr_s & ~full_s;
        assign rd_ok_s    = pop_s & ~empty_s[n];
        assign ovf_s[n]   = wr_s & full_s;
        assign udf_s[n]   = pop_s & empty_s[n];

        // Lane state, alignment and aligned-word registers.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                st_q          <= CS_INIT;
                cnt_q         <= '0;
                ecnt_q        <= '0;
                ifs_q         <= 1'b0;
                align_q       <= '0;
                prev_q        <= '0;
                aligned_q     <= '0;
                aligned_vld_q <= 1'b0;
            end else begin
                st_q          <= st_d;
                cnt_q         <= cnt_d;
                ecnt_q        <= ecnt_d;
                ifs_q         <= ifs_d;
                align_q       <= align_d;
                prev_q        <= cur_s;
                aligned_q     <= shifted_s[DATA_WIDTH-1:0];
                aligned_vld_q <= ifs_q & ~restart_s;
            end
        end

        // Deskew FIFO bookkeeping and registered output word.
        always_ff @(posedge clk_i) begin
            if (rst_i || restart_s) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                data_q   <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PW'(wr_ok_s);
                rd_ptr_q <= rd_ptr_q + PW'(rd_ok_s);
                count_q  <= count_q + (PW+1)'(wr_ok_s) - (PW+1)'(rd_ok_s);
                data_q   <= rd_ok_s ? mem_q[rd_ptr_q] : '0;
            end
        end

        // FIFO storage.
        always_ff @(posedge clk_i) begin
            if (wr_ok_s) begin
                mem_q[wr_ptr_q] <= aligned_q;
            end
        end

        assign ifs_s[n]                          = ifs_q;
        assign cgs_s[n]                          = (st_q == CS_DATA);
        assign data_o[n*DATA_WIDTH +: DATA_WIDTH] = data_q;
        assign octet_align_o[n*AW +: AW]         = align_q;
    end

    // Link release, SYNC~ and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_valid_q <= 1'b0;
            sync_no_q    <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            data_valid_q <= restart_s ? 1'b0 : (data_valid_q | start_s);
            sync_no_q    <= (&cgs_s) & ~sync_request_i;
            overflow_q   <= overflow_q | (|ovf_s);
            underflow_q  <= underflow_q | (|udf_s);
        end
    end

    assign data_valid_o = data_valid_q;
    assign sync_no      = sync_no_q;
    assign lane_cgs_o   = cgs_s;
    assign lane_ifs_o   = ifs_s;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;
endmodule

// File: tb/tb_jesd_rx_multilane_path.sv
// Directed-random bench for jesd_rx_multilane_path with a cycle-level
// reference model built from octet lists and shift-down FIFO arrays.
module tb_jesd_rx_multilane_path;
    localparam int L = 2, P = 4, DW = 32, D = 16, TH = 4, ETH = 3, AW = 2;

    logic clk_i = 1'b0;
    logic rst_i, sync_request_i, release_i;
    logic [L*DW-1:0] gtx_data_i, data_o;
    logic [L*P-1:0]  gtx_charisk_i, gtx_notintable_i, gtx_disperr_i;
    logic            data_valid_o, sync_no, overflow_o, underflow_o;
    logic [L-1:0]    lane_cgs_o, lane_ifs_o;
    logic [L*AW-1:0] octet_align_o;

    logic [DW-1:0] w [L];
    logic [P-1:0]  kk [L], de [L], nt [L];
    int tests = 0, failed = 0;

    // reference model state
    bit            m_in [L], m_ifs [L], m_av [L];
    int            m_kc [L], m_ec [L], m_al [L], m_cnt [L];
    logic [DW-1:0] m_prev [L], m_aw [L], m_dout [L];
    logic [DW-1:0] m_fifo [L][D];
    bit            m_valid, m_sync, m_ovf, m_udf;

    logic [DW-1:0] w1_ifs, w1_nxt, exp1;
    int            a0, a1, idx;
    bit            seen;

    jesd_rx_multilane_path dut (
        .clk_i(clk_i), .rst_i(rst_i), .gtx_data_i(gtx_data_i), .gtx_charisk_i(gtx_charisk_i),
        .gtx_notintable_i(gtx_notintable_i), .gtx_disperr_i(gtx_disperr_i),
        .sync_request_i(sync_request_i), .release_i(release_i), .data_o(data_o),
        .data_valid_o(data_valid_o), .sync_no(sync_no), .lane_cgs_o(lane_cgs_o),
        .lane_ifs_o(lane_ifs_o), .octet_align_o(octet_align_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    for (genvar g = 0; g < L; g++) begin : g_pack
        assign gtx_data_i[g*DW +: DW]      = w[g];
        assign gtx_charisk_i[g*P +: P]     = kk[g];
        assign gtx_disperr_i[g*P +: P]     = de[g];
        assign gtx_notintable_i[g*P +: P]  = nt[g];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < L; n++) begin
            m_in[n] = 0; m_ifs[n] = 0; m_av[n] = 0; m_kc[n] = 0; m_ec[n] = 0;
            m_al[n] = 0; m_cnt[n] = 0; m_prev[n] = '0; m_aw[n] = '0; m_dout[n] = '0;
        end
        m_valid = 0; m_sync = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic model_clock();
        bit nin [L]; int nkc [L]; int nec [L]; bit allk [L]; bit anye [L]; int first [L];
        bit restart, start, pop, all_ifs, all_ne, all_in, e, isk, wr;
        int ix, pre;
        logic [DW-1:0] aw;
        logic [7:0] o;
        restart = sync_request_i; all_ifs = 1; all_ne = 1; all_in = 1;
        for (int n = 0; n < L; n++) begin
            allk[n] = 1; anye[n] = 0; first[n] = -1;
            for (int k = 0; k < P; k++) begin
                e = nt[n][k] | de[n][k];
                o = w[n][8*k +: 8];
                isk = kk[n][k] && !e && (o == 8'hBC);
                anye[n] |= e;
                allk[n] &= isk;
                if (!isk && first[n] < 0) first[n] = k;
            end
            nin[n] = m_in[n]; nkc[n] = m_kc[n]; nec[n] = m_ec[n];
            if (sync_request_i) begin
                nin[n] = 0; nkc[n] = 0; nec[n] = 0;
            end else if (!m_in[n]) begin
                if (allk[n]) nkc[n] += P;
                else if (anye[n]) nkc[n] = 0;
                if (nkc[n] >= TH) begin nin[n] = 1; nkc[n] = 0; end
                nec[n] = 0;
            end else begin
                nec[n] = anye[n] ? m_ec[n] + 1 : 0;
                if (nec[n] >= ETH) begin nin[n] = 0; nec[n] = 0; end
            end
            if (m_in[n] && !nin[n]) restart = 1;
            all_ifs &= m_ifs[n]; all_ne &= (m_cnt[n] > 0); all_in &= m_in[n];
        end
        start = release_i && all_ifs && all_ne && !restart;
        pop = (m_valid || start) && !restart;
        for (int n = 0; n < L; n++) begin
            for (int k = 0; k < P; k++) begin
                ix = k + m_al[n];
                aw[8*k +: 8] = (ix < P) ? m_prev[n][8*ix +: 8] : w[n][8*(ix-P) +: 8];
            end
            wr = m_av[n] && m_ifs[n] && !restart;
            if (restart) begin
                m_cnt[n] = 0; m_dout[n] = '0;
            end else begin
                pre = m_cnt[n];
                m_dout[n] = '0;
                if (pop) begin
                    if (pre == 0) m_udf = 1;
                    else begin
                        m_dout[n] = m_fifo[n][0];
                        for (int i = 0; i < D - 1; i++) m_fifo[n][i] = m_fifo[n][i+1];
                        m_cnt[n]--;
                    end
                end
                if (wr) begin
                    if (pre == D) m_ovf = 1;
                    else begin m_fifo[n][m_cnt[n]] = m_aw[n]; m_cnt[n]++; end
                end
            end
            m_av[n] = m_ifs[n] && !restart;
            m_aw[n] = aw;
            if (restart) begin m_ifs[n] = 0; m_al[n] = 0; end
            else if (m_in[n] && !m_ifs[n] && !anye[n] && !allk[n]) begin m_ifs[n] = 1; m_al[n] = first[n]; end
            m_prev[n] = w[n];
        end
        m_sync = all_in && !sync_request_i;
        m_valid = restart ? 0 : (m_valid || start);
        for (int n = 0; n < L; n++) begin m_in[n] = nin[n]; m_kc[n] = nkc[n]; m_ec[n] = nec[n]; end
    endtask

    task automatic check_all();
        logic [L*DW-1:0] ed; logic [L-1:0] ec, ei; logic [L*AW-1:0] ea; int t;
        for (int n = 0; n < L; n++) begin
            ed[n*DW +: DW] = m_dout[n]; ec[n] = m_in[n]; ei[n] = m_ifs[n];
            t = m_al[n]; ea[n*AW +: AW] = t[AW-1:0];
        end
        check("m_data", data_o, ed);
        check("m_valid", data_valid_o, m_valid);
        check("m_sync_no", sync_no, m_sync);
        check("m_lane_cgs", lane_cgs_o, ec);
        check("m_lane_ifs", lane_ifs_o, ei);
        check("m_align", octet_align_o, ea);
        check("m_overflow", overflow_o, m_ovf);
        check("m_underflow", underflow_o, m_udf);
    endtask

    task automatic step();
        if (rst_i) model_reset(); else model_clock();
        @(posedge clk_i); #1;
        check_all();
    endtask

    task automatic lane_k(input int n);
        w[n] = 32'hBCBC_BCBC; kk[n] = 4'hF; de[n] = 4'h0; nt[n] = 4'h0;
    endtask

    task automatic lane_d(input int n, input logic [DW-1:0] v);
        w[n] = v; kk[n] = 4'h0; de[n] = 4'h0; nt[n] = 4'h0;
    endtask

    task automatic lane_ifs(input int n, input int a, input logic [DW-1:0] v);
        lane_d(n, v);
        for (int k = 0; k < a; k++) begin w[n][8*k +: 8] = 8'hBC; kk[n][k] = 1'b1; end
    endtask

    task automatic data_both();
        lane_d(0, $urandom); lane_d(1, $urandom);
    endtask

    initial begin
        rst_i = 1; sync_request_i = 0; release_i = 0;
        lane_d(0, 32'h0); lane_d(1, 32'h0);
        model_reset();
        step(); step();
        check("rst_valid", data_valid_o, 0);
        check("rst_sync_no", sync_no, 0);
        check("rst_cgs", lane_cgs_o, 0);
        rst_i = 0;

        // errored /K/ word keeps lane 0 in CS_INIT
        lane_k(0); de[0][2] = 1'b1; lane_d(1, $urandom); step();
        check("init_err_cgs", lane_cgs_o, 0);

        // CGS: one full /K/ word reaches threshold
        lane_k(0); lane_k(1); step();
        check("cgs_lanes", lane_cgs_o, 2'b11);
        check("cgs_sync_no_lag", sync_no, 0);
        step();
        check("cgs_sync_no", sync_no, 1);
        step();

        // lane 0 IFS with the worked example
        w[0] = 32'h11BC_BCBC; kk[0] = 4'b0111; de[0] = 0; nt[0] = 0; lane_k(1); step();
        check("ifs_align0", octet_align_o[1:0], 2'd3);
        check("ifs_lane0", lane_ifs_o, 2'b01);
        lane_d(0, 32'h5544_3322); lane_k(1); step();

        // lane 1 IFS two cycles later with a random alignment
        a1 = $urandom_range(0, 3);
        w1_ifs = $urandom; lane_d(0, $urandom); lane_ifs(1, a1, w1_ifs); w1_ifs = w[1]; step();
        release_i = 1;
        w1_nxt = $urandom; lane_d(0, $urandom); lane_d(1, w1_nxt); step();
        for (int k = 0; k < P; k++) begin
            idx = k + a1;
            exp1[8*k +: 8] = (idx < P) ? w1_ifs[8*idx +: 8] : w1_nxt[8*(idx-P) +: 8];
        end
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            data_both(); step();
            seen = data_valid_o;
        end
        check("release_valid", data_valid_o, 1);
        check("deskew_lane0", data_o[31:0], 32'h4433_2211);
        check("deskew_lane1", data_o[63:32], exp1);
        for (int c = 0; c < 6; c++) begin data_both(); step(); end

        // two error cycles then a clean one: no loss of sync
        for (int c = 0; c < 2; c++) begin data_both(); de[1] = 4'($urandom_range(1, 15)); step(); end
        data_both(); step();
        check("err2_cgs", lane_cgs_o, 2'b11);
        check("err2_valid", data_valid_o, 1);
        // three error cycles drop lane 1
        for (int c = 0; c < 3; c++) begin data_both(); de[1] = 4'($urandom_range(1, 15)); step(); end
        check("los_cgs1", lane_cgs_o[1], 0);
        check("los_valid", data_valid_o, 0);
        check("los_ifs", lane_ifs_o, 2'b00);
        lane_k(0); lane_k(1); step();
        check("los_sync_no", sync_no, 0);
        step();
        check("resync_sync_no", sync_no, 1);

        // overflow: no release while both lanes keep writing
        release_i = 0;
        a0 = $urandom_range(0, 3); a1 = $urandom_range(0, 3);
        lane_ifs(0, a0, $urandom); lane_ifs(1, a1, $urandom); step();
        for (int j = 1; j <= 21; j++) begin
            data_both(); step();
            if (j == 17) check("ovf_full_no_flag", overflow_o, 0);
            if (j == 18) check("ovf_set", overflow_o, 1);
        end
        check("ovf_sticky", overflow_o, 1);

        // release the full FIFOs, then a sync request mid-stream
        release_i = 1;
        data_both(); step();
        check("rel_full_valid", data_valid_o, 1);
        for (int c = 0; c < 4; c++) begin data_both(); step(); end
        sync_request_i = 1; data_both(); step();
        check("sreq_sync_no", sync_no, 0);
        check("sreq_cgs", lane_cgs_o, 2'b00);
        check("sreq_valid", data_valid_o, 0);
        check("sreq_ifs", lane_ifs_o, 2'b00);
        check("sreq_ovf_kept", overflow_o, 1);
        sync_request_i = 0; lane_k(0); lane_k(1); step();
        check("sreq_sync_no_after", sync_no, 0);

        // bring the link back up, then reset mid-stream
        step();
        lane_ifs(0, $urandom_range(0, 3), $urandom); lane_ifs(1, $urandom_range(0, 3), $urandom); step();
        for (int c = 0; c < 8; c++) begin data_both(); step(); end
        check("pre_rst_valid", data_valid_o, 1);
        rst_i = 1; data_both(); step();
        check("rst2_data", data_o, 64'h0);
        check("rst2_valid", data_valid_o, 0);
        check("rst2_sync_no", sync_no, 0);
        check("rst2_cgs", lane_cgs_o, 0);
        check("rst2_ifs", lane_ifs_o, 0);
        check("rst2_align", octet_align_o, 0);
        check("rst2_ovf", overflow_o, 0);
        check("rst2_udf", underflow_o, 0);
        rst_i = 0; lane_k(0); lane_k(1); step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
